// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the ALU execute stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SHW   = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: shift register, down-counter, fill select and done flag.
// ALU_SRA_EN builds the sign-fill path for SRA; without it SRA shifts in zeros like SRL.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] nxt,
  output logic             done
);

  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   cnt;
  logic             right;
  logic             fill;
`ifdef ALU_SRA_EN
  logic             arith;
`endif

  // NOTE: sreg is cleared with the control state so a discarded shift leaves no stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      right <= 1'b0;
`ifdef ALU_SRA_EN
      arith <= 1'b0;
`endif
    end else if (load) begin
      // NOTE: <= throughout, so every flop here samples the values from before the edge.
      sreg  <= din;
      cnt   <= amt;
      right <= (op != OP_SLL);
`ifdef ALU_SRA_EN
      arith <= (op == OP_SRA);
`endif
    end else if (step) begin
      sreg <= nxt;
      cnt  <= cnt - SHW'(1);
    end
  end

`ifdef ALU_SRA_EN
  // Repeating the current MSB each step keeps the captured sign bit.
  assign fill = arith & sreg[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  assign nxt  = right ? {fill, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
  assign done = (cnt == SHW'(1));

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ADD/SUB/logic, iterative shifts, result held until taken.
// ALU_SRA_EN selects sign-fill for opcode 111; otherwise it behaves exactly as SRL.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             cap;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shift_nxt;
  logic             shift_done;
  logic [SHW-1:0]   amt;

  assign amt = in2[SHW-1:0];

  // SUB reuses the adder as in1 + ~in2 + 1, so carry-out doubles as no-borrow.
  always_comb begin
    addend    = (op == OP_SUB) ? ~in2 : in2;
    sum       = {1'b0, in1} + {1'b0, addend} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    alu_res   = in1;
    alu_carry = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_XOR:  alu_res = in1 ^ in2;
      default: alu_res = in1;  // shift by zero passes the source through
    endcase
  end

  // NOTE: every signal written here gets a default first, so no branch can infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    cap       = 1'b0;
    res_d     = alu_res;
    carry_d   = alu_carry;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift(op) && (amt != '0)) begin
            load      = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            cap       = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        step    = 1'b1;
        res_d   = shift_nxt;
        carry_d = 1'b0;
        if (shift_done) begin
          cap       = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Flags are captured with the result so they stay coherent while the result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res   <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (cap) begin
      res   <= res_d;
      zero  <= (res_d == '0);
      carry <= carry_d;
    end
  end

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  alu_shift_iter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(step),
    .op  (op),
    .din (in1),
    .amt (amt),
    .nxt (shift_nxt),
    .done(shift_done)
  );

endmodule
